// File: rtl/console_writer.sv
// Text console writer; CONSOLE_WRITER_CLEAR_ON_RESET_EN makes a full-screen clear run after reset.
// Latency: a cell write is issued one cycle after its byte is accepted; fills write one cell per cycle.
// Backpressure: in_ready is low for the whole of a row or screen fill; in_valid is ignored meanwhile.
module console_writer #(
    parameter int COLUMNS = 80,
    parameter int ROWS    = 30
) (
    input  logic        CLK_PIXEL,
    input  logic        RESET_N,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  attribute,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_character,
    output logic [7:0]  wr_attribute,
    output logic [4:0]  top_row,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y
);

    typedef enum logic [1:0] {IDLE, CLEAR_ROW, CLEAR_ALL} state_t;

`ifdef CONSOLE_WRITER_CLEAR_ON_RESET_EN
    localparam state_t     RESET_STATE = CLEAR_ALL;
    localparam logic [7:0] RESET_ATTR  = 8'h07;
`else
    localparam state_t     RESET_STATE = IDLE;
    localparam logic [7:0] RESET_ATTR  = 8'h00;
`endif

    state_t      state;
    logic [11:0] fill_cnt;
    logic [11:0] fill_base;
    logic [7:0]  fill_attr;

    logic [5:0]  row_sum;
    logic [4:0]  phys_row;
    logic [11:0] cell_addr;
    logic [11:0] fill_last;
    logic [4:0]  top_next;
    logic        accept;
    logic        is_print;
    logic        at_last_col;
    logic        at_bottom;
    logic        do_lf;

    // Both operands are below ROWS, so one conditional subtract is enough for the modulo.
    assign row_sum     = {1'b0, top_row} + {1'b0, cursor_y};
    assign phys_row    = (row_sum >= 6'(ROWS)) ? 5'(row_sum - 6'(ROWS)) : row_sum[4:0];
    assign cell_addr   = 12'(phys_row) * 12'(COLUMNS) + 12'(cursor_x);
    assign fill_last   = (state == CLEAR_ALL) ? 12'(ROWS * COLUMNS - 1) : 12'(COLUMNS - 1);
    assign top_next    = (top_row == 5'(ROWS - 1)) ? 5'd0 : top_row + 5'd1;

    assign in_ready    = (state == IDLE);
    assign accept      = in_ready && in_valid;
    assign is_print    = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign at_last_col = (cursor_x == 7'(COLUMNS - 1));
    assign at_bottom   = (cursor_y == 5'(ROWS - 1));
    assign do_lf       = (in_data == 8'h0A) || (is_print && at_last_col);

    always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= RESET_STATE;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_character <= '0;
            wr_attribute <= '0;
            top_row      <= '0;
            cursor_x     <= '0;
            cursor_y     <= '0;
            fill_cnt     <= '0;
            fill_base    <= '0;
            fill_attr    <= RESET_ATTR;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_print) begin
                            wr_en        <= 1'b1;
                            wr_addr      <= cell_addr;
                            wr_character <= in_data;
                            wr_attribute <= attribute;
                            cursor_x     <= at_last_col ? 7'd0 : cursor_x + 7'd1;
                        end else if (in_data == 8'h0D) begin
                            cursor_x <= '0;
                        end else if (in_data == 8'h08) begin
                            if (cursor_x != 7'd0)
                                cursor_x <= cursor_x - 7'd1;
                        end else if (in_data == 8'h0C) begin
                            state     <= CLEAR_ALL;
                            fill_cnt  <= '0;
                            fill_base <= '0;
                            fill_attr <= attribute;
                        end
                        // After scrolling, the new bottom row is the physical row that used to be on top.
                        if (do_lf) begin
                            if (!at_bottom) begin
                                cursor_y <= cursor_y + 5'd1;
                            end else begin
                                top_row   <= top_next;
                                state     <= CLEAR_ROW;
                                fill_cnt  <= '0;
                                fill_base <= 12'(top_row) * 12'(COLUMNS);
                                fill_attr <= attribute;
                            end
                        end
                    end
                end
                CLEAR_ROW, CLEAR_ALL: begin
                    wr_en        <= 1'b1;
                    wr_addr      <= fill_base + fill_cnt;
                    wr_character <= 8'h20;
                    wr_attribute <= fill_attr;
                    fill_cnt     <= fill_cnt + 12'd1;
                    if (fill_cnt == fill_last) begin
                        state <= IDLE;
                        if (state == CLEAR_ALL) begin
                            cursor_x <= '0;
                            cursor_y <= '0;
                            top_row  <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_console_writer.sv
// Bench for console_writer: directed table, corner sequences and random bytes against a queue-based screen model.
module tb_console_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int LIMIT = 5000;

    logic        CLK_PIXEL = 1'b0;
    logic        RESET_N;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  attribute;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_character;
    logic [7:0]  wr_attribute;
    logic [4:0]  top_row;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;

    console_writer #(.COLUMNS(COLS), .ROWS(ROWS)) dut (
        .CLK_PIXEL   (CLK_PIXEL),
        .RESET_N     (RESET_N),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .attribute   (attribute),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_character(wr_character),
        .wr_attribute(wr_attribute),
        .top_row     (top_row),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y)
    );

    always #5 CLK_PIXEL = ~CLK_PIXEL;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  ch;
        logic [7:0]  at;
    } wr_t;

    typedef struct {
        logic [7:0] b;
        logic [7:0] a;
        int         cx;
        int         cy;
        int         top;
        int         nwr;
    } vec_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  fails = 0;
    int  wr_count = 0;
    int  last_addr = -1;
    int  m_cx = 0;
    int  m_cy = 0;
    int  m_top = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Screen model: logical cursor, scroll offset and the list of cell writes still expected.
    function automatic void push_fill(input int base, input int n, input logic [7:0] a);
        for (int i = 0; i < n; i++) exp_q.push_back('{12'(base + i), 8'h20, a});
    endfunction

    function automatic void model_lf(input logic [7:0] a);
        if (m_cy < ROWS - 1) m_cy++;
        else begin
            m_top = (m_top + 1) % ROWS;
            push_fill(((m_top + ROWS - 1) % ROWS) * COLS, COLS, a);
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b, input logic [7:0] a);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back('{12'(((m_top + m_cy) % ROWS) * COLS + m_cx), b, a});
            m_cx++;
            if (m_cx == COLS) begin
                m_cx = 0;
                model_lf(a);
            end
        end else if (b == 8'h0D) m_cx = 0;
        else if (b == 8'h0A) model_lf(a);
        else if (b == 8'h08) begin
            if (m_cx > 0) m_cx--;
        end else if (b == 8'h0C) begin
            push_fill(0, ROWS * COLS, a);
            m_cx = 0;
            m_cy = 0;
            m_top = 0;
        end
    endfunction

    always @(negedge CLK_PIXEL) begin
        if (RESET_N === 1'b1 && wr_en === 1'b1) begin
            wr_count++;
            last_addr = int'(wr_addr);
            if (exp_q.size() == 0) check("unexpected_write", {8'h0, wr_addr, wr_character, 4'h0}, 32'hFFFFFFFF);
            else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_cell", {8'h0, wr_addr, wr_character, wr_attribute}, {8'h0, e.addr, e.ch, e.at});
            end
        end
    end

    // Holds in_valid until accepted; attribute wanders while blocked, so fills must use the latched one.
    task automatic send(input logic [7:0] b, input logic [7:0] a);
        int n;
        n = 0;
        @(negedge CLK_PIXEL);
        in_data = b;
        in_valid = 1'b1;
        while (n < LIMIT && !in_ready) begin
            attribute = 8'($urandom);
            @(negedge CLK_PIXEL);
            n++;
        end
        attribute = a;
        if (n >= LIMIT) begin
            check("accept_timeout", 32'(n), 32'(LIMIT - 1));
            in_valid = 1'b0;
        end else begin
            @(posedge CLK_PIXEL);
            model_byte(b, a);
            @(negedge CLK_PIXEL);
            in_valid = 1'b0;
            if (b >= 8'h20 && b <= 8'h7E) check("write_latency", 32'(wr_en), 32'd1);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!in_ready && n < LIMIT) begin
            @(negedge CLK_PIXEL);
            n++;
        end
        if (n >= LIMIT) check("idle_timeout", 32'(n), 32'(LIMIT - 1));
    endtask

    task automatic settle();
        @(negedge CLK_PIXEL);
        #2;
    endtask

    task automatic check_cursor(input string name, input int cx, input int cy, input int top);
        check(name, {15'h0, cursor_x, cursor_y, top_row}, {15'h0, 7'(cx), 5'(cy), 5'(top)});
    endtask

    vec_t tbl[14];

    initial begin
        int n;
        int base;
        logic [7:0] b;
        int r;

        tbl[0]  = '{8'h41, 8'h1F, 1, 0, 0, 1};
        tbl[1]  = '{8'h0D, 8'h00, 0, 0, 0, 0};
        tbl[2]  = '{8'h0A, 8'h00, 0, 1, 0, 0};
        tbl[3]  = '{8'h08, 8'h00, 0, 1, 0, 0};
        tbl[4]  = '{8'h42, 8'h2E, 1, 1, 0, 1};
        tbl[5]  = '{8'h08, 8'h00, 0, 1, 0, 0};
        tbl[6]  = '{8'h09, 8'h00, 0, 1, 0, 0};
        tbl[7]  = '{8'h7F, 8'h00, 0, 1, 0, 0};
        tbl[8]  = '{8'h7E, 8'h44, 1, 1, 0, 1};
        tbl[9]  = '{8'h20, 8'h55, 2, 1, 0, 1};
        tbl[10] = '{8'h00, 8'h00, 2, 1, 0, 0};
        tbl[11] = '{8'h1F, 8'h00, 2, 1, 0, 0};
        tbl[12] = '{8'h0B, 8'h00, 2, 1, 0, 0};
        tbl[13] = '{8'hFF, 8'h00, 2, 1, 0, 0};

        RESET_N = 1'b0;
        in_data = 8'h00;
        in_valid = 1'b0;
        attribute = 8'h00;
        repeat (3) @(negedge CLK_PIXEL);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_data", {8'h0, wr_addr, wr_character, wr_attribute}, 32'h0);
        check_cursor("rst_cursor", 0, 0, 0);
        RESET_N = 1'b1;
        @(negedge CLK_PIXEL);
        check("ready_after_reset", 32'(in_ready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            base = wr_count;
            send(tbl[i].b, tbl[i].a);
            settle();
            check($sformatf("tbl%0d_cursor", i), {15'h0, cursor_x, cursor_y, top_row},
                  {15'h0, 7'(tbl[i].cx), 5'(tbl[i].cy), 5'(tbl[i].top)});
            check($sformatf("tbl%0d_writes", i), 32'(wr_count - base), 32'(tbl[i].nwr));
        end

        // A full row from home wraps onto the next line without scrolling.
        send(8'h0C, 8'h07);
        wait_idle(n);
        for (int i = 0; i < COLS; i++) send(8'(8'h30 + i % 40), 8'h1A);
        settle();
        check("row_last_addr", 32'(last_addr), 32'd79);
        check_cursor("row_wrap_cursor", 0, 1, 0);

        // Line feed on the bottom row scrolls and blanks the recycled physical row.
        send(8'h0C, 8'h07);
        wait_idle(n);
        for (int i = 0; i < ROWS - 1; i++) send(8'h0A, 8'h00);
        for (int i = 0; i < 5; i++) send(8'h61, 8'h02);
        settle();
        check_cursor("pre_scroll_cursor", 5, 29, 0);
        base = wr_count;
        send(8'h0A, 8'h3C);
        wait_idle(n);
        check("scroll_busy_cycles", 32'(n), 32'd80);
        settle();
        check("scroll_writes", 32'(wr_count - base), 32'd80);
        check("scroll_last_addr", 32'(last_addr), 32'd79);
        check_cursor("scroll_cursor", 5, 29, 1);

        // Full clear, then a byte held valid through a second clear.
        base = wr_count;
        send(8'h0C, 8'h07);
        wait_idle(n);
        check("clear_busy_cycles", 32'(n), 32'd2400);
        settle();
        check("clear_writes", 32'(wr_count - base), 32'd2400);
        check("clear_last_addr", 32'(last_addr), 32'd2399);
        check_cursor("clear_cursor", 0, 0, 0);
        send(8'h0C, 8'h07);
        send(8'h5A, 8'h1E);
        settle();
        check_cursor("held_valid_cursor", 1, 0, 0);

        // Control bytes at column 0 leave the cursor alone.
        send(8'h0D, 8'h00);
        for (int i = 0; i < 3; i++) send(8'h0A, 8'h00);
        settle();
        base = wr_count;
        send(8'h08, 8'h00);
        send(8'h0D, 8'h00);
        send(8'h09, 8'h00);
        settle();
        check_cursor("ctrl_cursor", 0, 3, 0);
        check("ctrl_writes", 32'(wr_count - base), 32'd0);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) b = 8'h0C;
            else if (r < 20) b = 8'h0A;
            else if (r < 30) b = 8'h0D;
            else if (r < 40) b = 8'h08;
            else if (r < 45) b = 8'($urandom_range(0, 31));
            else if (r < 50) b = 8'($urandom_range(127, 255));
            else b = 8'($urandom_range(32, 126));
            send(b, 8'($urandom));
            wait_idle(n);
            check("rand_cursor", {15'h0, cursor_x, cursor_y, top_row},
                  {15'h0, 7'(m_cx), 5'(m_cy), 5'(m_top)});
        end
        settle();
        check("rand_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a screen fill aborts it at once.
        send(8'h0C, 8'h07);
        #2;
        base = wr_count;
        n = 0;
        while (wr_count - base < 100 && n < LIMIT) begin
            @(negedge CLK_PIXEL);
            #2;
            n++;
        end
        check("fill_reached_100", 32'(wr_count - base), 32'd100);
        RESET_N = 1'b0;
        #1;
        check("abort_wr_en", 32'(wr_en), 32'd0);
        check("abort_wr_data", {8'h0, wr_addr, wr_character, wr_attribute}, 32'h0);
        check_cursor("abort_cursor", 0, 0, 0);
        exp_q.delete();
        m_cx = 0;
        m_cy = 0;
        m_top = 0;
        base = wr_count;
        repeat (2) @(negedge CLK_PIXEL);
        RESET_N = 1'b1;
        @(negedge CLK_PIXEL);
        check("abort_no_writes", 32'(wr_count - base), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        send(8'h41, 8'h1F);
        settle();
        check("post_abort_addr", 32'(last_addr), 32'd0);
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
